// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the parametrised register file
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int ZERO_ADDR     = 0;
   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - clear-sweep sequencer: walks every address writing zero, then hands over to RUN
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = $clog2(DEFAULT_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   output logic              busy,
   output logic              sweep_we,
   output logic [ADDR_W-1:0] sweep_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // A clear request during an active sweep is ignored rather than restarting it.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         CLEAR: begin
            if (cnt == LAST) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RUN: begin
            if (clear) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = CLEAR;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      busy       = (state == CLEAR);
      sweep_we   = (state == CLEAR);
      sweep_addr = cnt;
   end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with clear sweep and zero register
// Optional same-cycle write-to-read forwarding: REGFILE_BYPASS_EN
module regfile_param
   import regfile_pkg::*;
#(
   parameter  int WIDTH  = DEFAULT_WIDTH,
   parameter  int DEPTH  = DEFAULT_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Wenable,
   input  logic [ADDR_W-1:0] WrtAdd,
   input  logic [WIDTH-1:0]  DIn,
   input  logic [ADDR_W-1:0] RdAdd1,
   input  logic [ADDR_W-1:0] RdAdd2,
   input  logic              Clear,
   output logic [WIDTH-1:0]  DataA,
   output logic [WIDTH-1:0]  DataB,
   output logic              Busy,
   output logic              WrDropped
);

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic              busy;
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              ok_w, ok_1, ok_2;
   logic              wr_acc, wr_drop;
   logic [WIDTH-1:0]  rd_a, rd_b;

   regfile_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk        (clk),
      .rst_n      (Reset),
      .clear      (Clear),
      .busy       (busy),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // Register 0 and addresses past the last register are dead; the range test vanishes for power-of-two depths.
   if (DEPTH == (1 << ADDR_W)) begin : g_full
      assign ok_w = (WrtAdd != ZERO);
      assign ok_1 = (RdAdd1 != ZERO);
      assign ok_2 = (RdAdd2 != ZERO);
   end else begin : g_part
      assign ok_w = (WrtAdd != ZERO) && (WrtAdd <= LAST);
      assign ok_1 = (RdAdd1 != ZERO) && (RdAdd1 <= LAST);
      assign ok_2 = (RdAdd2 != ZERO) && (RdAdd2 <= LAST);
   end

   always_comb begin
      wr_drop = Wenable && (busy || Clear);
      wr_acc  = Wenable && !busy && !Clear && ok_w;
   end

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (ok_1) begin
         rd_a = mem[RdAdd1];
`ifdef REGFILE_BYPASS_EN
         if (wr_acc && (RdAdd1 == WrtAdd)) rd_a = DIn;
`endif
      end
      if (ok_2) begin
         rd_b = mem[RdAdd2];
`ifdef REGFILE_BYPASS_EN
         if (wr_acc && (RdAdd2 == WrtAdd)) rd_b = DIn;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem[sweep_addr] <= '0;
      end else if (wr_acc) begin
         mem[WrtAdd] <= DIn;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         DataA     <= '0;
         DataB     <= '0;
         WrDropped <= 1'b0;
      end else begin
         DataA     <= busy ? '0 : rd_a;
         DataB     <= busy ? '0 : rd_b;
         WrDropped <= wr_drop;
      end
   end

   assign Busy = busy;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized and directed checks of regfile_param against a behavioural model
module tb_regfile_param;

   localparam int W  = 32, D  = 32, AW  = 5;
   localparam int W2 = 16, D2 = 12, AW2 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          Reset, Wenable, Clear, Busy, WrDropped;
   logic [AW-1:0] WrtAdd, RdAdd1, RdAdd2;
   logic [W-1:0]  DIn, DataA, DataB;

   logic           Reset2, Wenable2, Clear2, Busy2, WrDropped2;
   logic [AW2-1:0] WrtAdd2, RdAdd12, RdAdd22;
   logic [W2-1:0]  DIn2, DataA2, DataB2;

   regfile_param #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .Reset(Reset), .Wenable(Wenable), .WrtAdd(WrtAdd), .DIn(DIn),
      .RdAdd1(RdAdd1), .RdAdd2(RdAdd2), .Clear(Clear),
      .DataA(DataA), .DataB(DataB), .Busy(Busy), .WrDropped(WrDropped)
   );

   regfile_param #(.WIDTH(W2), .DEPTH(D2)) dut2 (
      .clk(clk), .Reset(Reset2), .Wenable(Wenable2), .WrtAdd(WrtAdd2), .DIn(DIn2),
      .RdAdd1(RdAdd12), .RdAdd2(RdAdd22), .Clear(Clear2),
      .DataA(DataA2), .DataB(DataB2), .Busy(Busy2), .WrDropped(WrDropped2)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mdl [D];
   int           sweep_left;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] mread(input logic [AW-1:0] a);
      return (a == '0) ? '0 : mdl[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < D; i++) mdl[i] = '0;
      sweep_left = D;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of the main instance, with expectations derived from the model before the edge.
   task automatic cycle(input string tag);
      logic         busy_e, drop_e, acc;
      logic [W-1:0] ea, eb;
      busy_e = (sweep_left > 0);
      drop_e = Wenable && (busy_e || Clear);
      acc    = Wenable && !busy_e && !Clear && (WrtAdd != '0);
      ea     = busy_e ? '0 : mread(RdAdd1);
      eb     = busy_e ? '0 : mread(RdAdd2);
`ifdef REGFILE_BYPASS_EN
      if (acc && RdAdd1 == WrtAdd) ea = DIn;
      if (acc && RdAdd2 == WrtAdd) eb = DIn;
`endif
      tick();
      if (busy_e) sweep_left--;
      else if (Clear) model_clear();
      else if (acc) mdl[WrtAdd] = DIn;
      chk({tag, "_dataa"}, DataA, ea);
      chk({tag, "_datab"}, DataB, eb);
      chk({tag, "_busy"}, 32'(Busy), 32'(sweep_left > 0));
      chk({tag, "_wrdrop"}, 32'(WrDropped), 32'(drop_e));
   endtask

   task automatic idle();
      Wenable = 1'b0; Clear = 1'b0; WrtAdd = '0; DIn = '0; RdAdd1 = '0; RdAdd2 = '0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      idle();
      while (Busy && n < 100) begin
         cycle(tag);
         n++;
      end
      chk({tag, "_drained"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      int n;
      logic [W-1:0] exp5;

      idle();
      Reset = 1'b0;
      Reset2 = 1'b0; Wenable2 = 1'b0; Clear2 = 1'b0; WrtAdd2 = '0; DIn2 = '0; RdAdd12 = '0; RdAdd22 = '0;
      model_clear();
      repeat (3) tick();
      chk("rst_dataa", DataA, '0);
      chk("rst_datab", DataB, '0);
      chk("rst_busy", 32'(Busy), 32'd1);
      chk("rst_wrdrop", 32'(WrDropped), 32'd0);

      Reset = 1'b1;
      n = 0;
      while (Busy && n < 100) begin
         cycle("sweep");
         n++;
      end
      chk("sweep_len", n, D);

      for (int i = 0; i < D; i++) begin
         RdAdd1 = AW'(i); RdAdd2 = AW'(D - 1 - i);
         cycle("zero_rd");
      end

      Wenable = 1'b1; WrtAdd = 5'd1; DIn = 32'h78493052;
      cycle("wr1");
      WrtAdd = 5'd2; DIn = 32'h73245243;
      cycle("wr2");
      Wenable = 1'b0; RdAdd1 = 5'd1; RdAdd2 = 5'd2;
      cycle("rd12");
      chk("rd12_const_a", DataA, 32'h78493052);
      chk("rd12_const_b", DataB, 32'h73245243);

      Wenable = 1'b1; WrtAdd = 5'd0; DIn = 32'hDEADBEEF;
      cycle("wr0");
      Wenable = 1'b0; RdAdd1 = 5'd0; RdAdd2 = 5'd0;
      cycle("rd0");
      chk("rd0_const", DataA, '0);
      chk("rd0_nodrop", 32'(WrDropped), 32'd0);

`ifdef REGFILE_BYPASS_EN
      exp5 = 32'h12345678;
`else
      exp5 = '0;
`endif
      Wenable = 1'b1; WrtAdd = 5'd5; DIn = 32'h12345678; RdAdd1 = 5'd5; RdAdd2 = 5'd5;
      cycle("byp");
      chk("byp_const_a", DataA, exp5);
      chk("byp_const_b", DataB, exp5);
      Wenable = 1'b0;
      cycle("byp_after");
      chk("byp_after_const", DataA, 32'h12345678);

      for (int i = 0; i < 400; i++) begin
         Wenable = 1'($urandom_range(0, 1));
         WrtAdd  = AW'($urandom_range(0, D - 1));
         DIn     = $urandom;
         Clear   = ($urandom_range(0, 59) == 0);
         RdAdd1  = ($urandom_range(0, 3) == 0) ? WrtAdd : AW'($urandom_range(0, D - 1));
         RdAdd2  = ($urandom_range(0, 3) == 0) ? WrtAdd : AW'($urandom_range(0, D - 1));
         cycle("rand");
      end
      drain("rand");

      Clear = 1'b1; Wenable = 1'b1; WrtAdd = 5'd7; DIn = 32'hCAFEF00D;
      cycle("clr_start");
      chk("clr_drop", 32'(WrDropped), 32'd1);
      Clear = 1'b0; WrtAdd = 5'd9; DIn = 32'h0BADF00D;
      cycle("clr_busywr");
      chk("clr_busywr_drop", 32'(WrDropped), 32'd1);
      Wenable = 1'b0;
      n = 1;
      while (Busy && n < 100) begin
         cycle("clr_sweep");
         n++;
      end
      chk("clr_len", n, D);
      for (int i = 0; i < D; i++) begin
         RdAdd1 = AW'(i); RdAdd2 = AW'(i);
         cycle("clr_zero");
      end

      Wenable = 1'b1; WrtAdd = 5'd3; DIn = 32'h55AA55AA;
      cycle("pre_arst");
      idle();
      #2;
      Reset = 1'b0;
      #1;
      model_clear();
      chk("arst_dataa", DataA, '0);
      chk("arst_busy", 32'(Busy), 32'd1);
      chk("arst_wrdrop", 32'(WrDropped), 32'd0);
      tick();
      Reset = 1'b1;
      drain("arst");
      RdAdd1 = 5'd3;
      cycle("arst_rd3");

      Reset2 = 1'b1;
      repeat (7) tick();
      chk("w16_midsweep_busy", 32'(Busy2), 32'd1);
      Reset2 = 1'b0;
      #1;
      chk("w16_arst_busy", 32'(Busy2), 32'd1);
      chk("w16_arst_dataa", 32'(DataA2), 32'd0);
      tick();
      Reset2 = 1'b1;
      n = 0;
      while (Busy2 && n < 100) begin
         tick();
         n++;
      end
      chk("w16_sweep_len", n, D2);
      Wenable2 = 1'b1; WrtAdd2 = 4'd11; DIn2 = 16'h1234;
      tick();
      WrtAdd2 = 4'd13; DIn2 = 16'hBEEF;
      tick();
      chk("w16_oor_nodrop", 32'(WrDropped2), 32'd0);
      Wenable2 = 1'b0; RdAdd12 = 4'd13; RdAdd22 = 4'd11;
      tick();
      chk("w16_rd13", 32'(DataA2), 32'd0);
      chk("w16_rd11", 32'(DataB2), 32'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file: next generation of the team's 32×32 two-read/one-write register file. Generalised in width and depth, with registered reads, optional write-to-read bypass, a hardwired-zero register, and a hardware clear sweep that initialises storage after reset or on request. Sits in the datapath between writeback (DIn/WrtAdd) and operand fetch (DataA/DataB).

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 32, number of registers (any value ≥ 2, power of two not required)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)
- clk  input  1  single clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Wenable  input  1  write request this cycle
- WrtAdd  input  ADDR_W  write address
- DIn  input  WIDTH  write data
- RdAdd1  input  ADDR_W  read address, port A
- RdAdd2  input  ADDR_W  read address, port B
- Clear  input  1  single-cycle pulse; starts a clear sweep
- DataA  output  WIDTH  registered read data, port A
- DataB  output  WIDTH  registered read data, port B
- Busy  output  1  high while clear sweep runs; writes and reads blocked
- WrDropped  output  1  registered one-cycle pulse: a write was rejected

## Operation
- FSM states: CLEAR, RUN. Reset forces CLEAR with sweep counter = 0.
- CLEAR: each cycle writes 0 to register[counter], counter += 1; after writing DEPTH-1 → RUN. Busy = 1 throughout.
- RUN: Busy = 0. Clear = 1 → CLEAR, counter = 0. Otherwise Wenable = 1 writes DIn to register[WrtAdd].
- Register 0 hardwired zero: writes to address 0 silently ignored (no WrDropped); reads return 0.
- Address ≥ DEPTH: writes ignored (no WrDropped); reads return 0.
- Wenable = 1 while Busy, or in the RUN cycle where Clear = 1 → write discarded, WrDropped = 1 next cycle.
- Clear while already in CLEAR: ignored; sweep continues without restart.
- Reads: DataA/DataB capture register[RdAdd1]/[RdAdd2] every cycle; while Busy both capture 0.
- Both read ports may address the same register; both return the same value.

## Timing
- Reset values: DataA = 0, DataB = 0, Busy = 1, WrDropped = 0, state CLEAR, counter = 0.
- Reset assertion mid-sweep or mid-operation: immediate async return to reset values; sweep restarts from address 0 after deassertion.
- Sweep length: exactly DEPTH cycles after reset deassertion or the Clear cycle; first write accepted in cycle DEPTH+1.
- Read latency: 1 cycle (address at edge N, data valid after edge N+1).
- Write visibility: a write at edge N is returned by a read issued at edge N+1 or later.
- Same-cycle write/read to same address: governed by REGFILE_BYPASS_EN.

## Configuration
- REGFILE_BYPASS_EN defined: read at address equal to WrtAdd, in a cycle where the write is accepted, returns DIn (new data) on the next cycle. Never applies to address 0, out-of-range addresses, or rejected writes.
- Undefined: same-cycle read returns the pre-write contents (old data).

## Structure
- Package regfile_pkg: state enum (CLEAR, RUN), zero-register address constant, default WIDTH/DEPTH constants.
- Sub-module regfile_clear_fsm: state register, sweep counter, Busy, sweep write strobe/address; top level holds storage, read registers, bypass mux, WrDropped.

## Test plan
- Reset low → DataA = DataB = 0, Busy = 1; release → Busy stays high exactly 32 cycles (DEPTH = 32), then 0; every register reads 0.
- Write 32'h78493052 to addr 1, next cycle write 32'h73245243 to addr 2; read RdAdd1 = 1, RdAdd2 = 2 → DataA = 32'h78493052, DataB = 32'h73245243.
- Write 32'hDEADBEEF to addr 0 → read addr 0 returns 0, WrDropped stays 0.
- Write 32'h12345678 to addr 5 and read addr 5 in same cycle → 32'h12345678 with REGFILE_BYPASS_EN, prior value (0) without.
- Clear pulse with Wenable = 1 → WrDropped = 1 next cycle, Busy = 1 for 32 cycles, write during Busy also flags WrDropped, all registers read 0 afterwards.
- WIDTH = 16, DEPTH = 12: Reset asserted mid-sweep at count 7 → sweep restarts, Busy high 12 cycles; write to addr 13 ignored, reads of addr 13 return 0.
